// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared BCD width constant and BCD helper functions for the time-field counters
package clock_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 16;
  localparam int VEC_W      = BCD_W * MAX_DIGITS;

  // Decimal integer to packed BCD, digit 0 in the low nibble; only the low `digits` nibbles are filled.
  function automatic logic [VEC_W-1:0] to_bcd(input int value, input int digits);
    logic [VEC_W-1:0] res;
    int v;
    res = '0;
    v   = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) begin
        res[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
        v = v / 10;
      end
    end
    return res;
  endfunction

  function automatic logic bcd_valid(input logic [VEC_W-1:0] vec, input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if ((i < digits) && (vec[i*BCD_W +: BCD_W] > 4'd9)) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// rtl/bcd_digit_step.sv - single BCD digit increment/decrement stage with ripple carry/borrow
module bcd_digit_step
  import clock_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             up,
  input  logic             down,
  input  logic             carry_in,
  output logic [BCD_W-1:0] next_digit,
  output logic             carry_out
);

  // carry_in means "this digit must step"; carry_out is a carry when counting up, a borrow when down.
  always_comb begin
    next_digit = digit;
    carry_out  = 1'b0;
    if (carry_in) begin
      if (down) begin
        if (digit == 4'd0) begin
          next_digit = 4'd9;
          carry_out  = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
        end
      end else if (up) begin
        if (digit >= 4'd9) begin
          next_digit = 4'd0;
          carry_out  = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_wrap_counter.sv
// rtl/bcd_wrap_counter.sv - multi-digit BCD counter with MIN..MAX wrap, run/set modes, parallel load and carry pulse
module bcd_wrap_counter
  import clock_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int MIN_VALUE = 0,
  parameter int MAX_VALUE = 23
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    set_mode,
  input  logic                    inc,
  input  logic                    dec,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_value,
  output logic [BCD_W*DIGITS-1:0] qout,
  output logic                    cout,
  output logic                    at_max,
  output logic                    load_err
);

  localparam int W = BCD_W * DIGITS;
  localparam logic [VEC_W-1:0] MIN_FULL = to_bcd(MIN_VALUE, DIGITS);
  localparam logic [VEC_W-1:0] MAX_FULL = to_bcd(MAX_VALUE, DIGITS);
  localparam logic [W-1:0]     MIN_BCD  = MIN_FULL[W-1:0];
  localparam logic [W-1:0]     MAX_BCD  = MAX_FULL[W-1:0];

  logic [W-1:0]    qout_q, qout_d;
  logic            cout_q, cout_d;
  logic            load_err_q, load_err_d;
  logic [W-1:0]    stepped;
  logic [DIGITS:0] carry;
  logic            step_down;
  logic            at_min;
  logic            wrap_up, wrap_down;
  logic            load_ok;

  // Only a lone dec in set mode counts down; every other step through the chain is upward.
  assign step_down = set_mode & dec & ~inc;
  assign carry[0]  = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_step u_digit (
      .digit      (qout_q[g*BCD_W +: BCD_W]),
      .up         (~step_down),
      .down       (step_down),
      .carry_in   (carry[g]),
      .next_digit (stepped[g*BCD_W +: BCD_W]),
      .carry_out  (carry[g+1])
    );
  end

  assign at_max = (qout_q == MAX_BCD);
  assign at_min = (qout_q == MIN_BCD);

  // Top-digit overflow/underflow can only coincide with the range edge, so it folds into the wrap.
  assign wrap_up   = at_max | carry[DIGITS];
  assign wrap_down = at_min | carry[DIGITS];

  // Valid BCD orders the same as its bit pattern, so range checks compare the vectors directly.
  assign load_ok = bcd_valid(VEC_W'(load_value), DIGITS)
                   && (load_value >= MIN_BCD) && (load_value <= MAX_BCD);

  always_comb begin
    qout_d     = qout_q;
    cout_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        qout_d = load_value;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (set_mode) begin
      if (inc & ~dec) begin
        qout_d = wrap_up ? MIN_BCD : stepped;
      end else if (dec & ~inc) begin
        qout_d = wrap_down ? MAX_BCD : stepped;
      end
    end else if (tick) begin
      if (wrap_up) begin
        qout_d = MIN_BCD;
        cout_d = 1'b1;
      end else begin
        qout_d = stepped;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qout_q     <= MIN_BCD;
      cout_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      qout_q     <= qout_d;
      cout_q     <= cout_d;
      load_err_q <= load_err_d;
    end
  end

  assign qout     = qout_q;
  assign cout     = cout_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_wrap_counter.sv
// tb/tb_bcd_wrap_counter.sv - self-checking bench: three counter ranges (0-23, 1-12, 0-59) against an integer model
module tb_bcd_wrap_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       set_mode = 1'b0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;

  logic [7:0] q  [3];
  logic       co [3];
  logic       am [3];
  logic       le [3];

  int n_checks = 0;
  int n_errors = 0;

  int m_cnt [3];
  int m_min [3] = '{0, 1, 0};
  int m_max [3] = '{23, 12, 59};
  bit m_cout [3];
  bit m_err  [3];

  always #5 clk = ~clk;

  bcd_wrap_counter #(.DIGITS(2), .MIN_VALUE(0), .MAX_VALUE(23)) u_h24 (
    .clk(clk), .reset(reset), .tick(tick), .set_mode(set_mode), .inc(inc), .dec(dec),
    .load(load), .load_value(load_value), .qout(q[0]), .cout(co[0]), .at_max(am[0]), .load_err(le[0])
  );

  bcd_wrap_counter #(.DIGITS(2), .MIN_VALUE(1), .MAX_VALUE(12)) u_h12 (
    .clk(clk), .reset(reset), .tick(tick), .set_mode(set_mode), .inc(inc), .dec(dec),
    .load(load), .load_value(load_value), .qout(q[1]), .cout(co[1]), .at_max(am[1]), .load_err(le[1])
  );

  bcd_wrap_counter #(.DIGITS(2), .MIN_VALUE(0), .MAX_VALUE(59)) u_m60 (
    .clk(clk), .reset(reset), .tick(tick), .set_mode(set_mode), .inc(inc), .dec(dec),
    .load(load), .load_value(load_value), .qout(q[2]), .cout(co[2]), .at_max(am[2]), .load_err(le[2])
  );

  function automatic logic [7:0] bcd8(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k]  = m_min[k];
      m_cout[k] = 1'b0;
      m_err[k]  = 1'b0;
    end
  endtask

  task automatic model_step();
    bit lv_ok;
    int lv_val;
    lv_ok  = (load_value[3:0] <= 4'd9) && (load_value[7:4] <= 4'd9);
    lv_val = int'(load_value[7:4]) * 10 + int'(load_value[3:0]);
    for (int k = 0; k < 3; k++) begin
      m_cout[k] = 1'b0;
      m_err[k]  = 1'b0;
      if (load) begin
        if (lv_ok && lv_val >= m_min[k] && lv_val <= m_max[k]) m_cnt[k] = lv_val;
        else m_err[k] = 1'b1;
      end else if (set_mode) begin
        if (inc && !dec) m_cnt[k] = (m_cnt[k] == m_max[k]) ? m_min[k] : m_cnt[k] + 1;
        if (dec && !inc) m_cnt[k] = (m_cnt[k] == m_min[k]) ? m_max[k] : m_cnt[k] - 1;
      end else if (tick) begin
        if (m_cnt[k] == m_max[k]) begin
          m_cnt[k]  = m_min[k];
          m_cout[k] = 1'b1;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s.qout%0d", tag, k), 32'(q[k]), 32'(bcd8(m_cnt[k])));
      check($sformatf("%s.cout%0d", tag, k), 32'(co[k]), 32'(m_cout[k]));
      check($sformatf("%s.load_err%0d", tag, k), 32'(le[k]), 32'(m_err[k]));
      check($sformatf("%s.at_max%0d", tag, k), 32'(am[k]), 32'(m_cnt[k] == m_max[k]));
    end
  endtask

  task automatic step(input logic t, input logic s, input logic i, input logic d,
                      input logic l, input logic [7:0] lv, input string tag);
    @(negedge clk);
    tick = t; set_mode = s; inc = i; dec = d; load = l; load_value = lv;
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  // Asserts reset between edges, checks the immediate clear, holds it over one edge, then releases.
  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    tick = 1'b0; set_mode = 1'b0; inc = 1'b0; dec = 1'b0; load = 1'b0;
    @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic t, s, i, d, l;
    logic [7:0] lv;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 30; n++) step(1, 0, 0, 0, 0, 8'h00, "run30");
    check("run30_final", 32'(q[0]), 32'h06);

    step(0, 0, 0, 0, 1, 8'h12, "ld12");
    step(1, 0, 0, 0, 0, 8'h00, "h12_wrap");
    check("h12_wrap_q", 32'(q[1]), 32'h01);
    check("h12_wrap_cout", 32'(co[1]), 32'h1);
    step(0, 1, 0, 1, 0, 8'h00, "h12_dec");
    check("h12_dec_q", 32'(q[1]), 32'h12);
    check("h12_dec_cout", 32'(co[1]), 32'h0);

    step(0, 0, 0, 0, 1, 8'h10, "ld10");
    step(0, 1, 0, 1, 0, 8'h00, "dec_borrow");
    check("dec_borrow_q", 32'(q[0]), 32'h09);
    step(0, 1, 1, 1, 0, 8'h00, "inc_dec");
    check("inc_dec_q", 32'(q[0]), 32'h09);
    step(1, 1, 0, 0, 0, 8'h00, "set_tick");
    check("set_tick_q", 32'(q[0]), 32'h09);

    step(0, 0, 0, 0, 1, 8'h17, "ld17");
    check("ld17_q", 32'(q[0]), 32'h17);
    step(0, 0, 0, 0, 1, 8'h1A, "ld1A");
    check("ld1A_q", 32'(q[0]), 32'h17);
    check("ld1A_err", 32'(le[0]), 32'h1);
    step(0, 0, 0, 0, 1, 8'h24, "ld24");
    check("ld24_q", 32'(q[0]), 32'h17);
    check("ld24_err", 32'(le[0]), 32'h1);
    step(1, 0, 0, 0, 1, 8'h05, "ld05_tick");
    check("ld05_tick_q", 32'(q[0]), 32'h05);
    check("ld05_tick_cout", 32'(co[0]), 32'h0);

    step(0, 0, 0, 0, 1, 8'h23, "ld23");
    step(1, 0, 0, 0, 0, 8'h00, "wrap_then_rst");
    mid_reset();

    step(0, 0, 0, 0, 1, 8'h37, "ld37");
    mid_reset();
    check("m60_rst_q", 32'(q[2]), 32'h00);
    for (int n = 0; n < 10; n++) step(1, 0, 0, 0, 0, 8'h00, "post_rst");
    check("m60_post_rst_q", 32'(q[2]), 32'h10);

    for (int n = 0; n < 3000; n++) begin
      s  = ($urandom_range(0, 3) == 0);
      t  = 1'($urandom_range(0, 1));
      i  = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 2) == 0);
      l  = ($urandom_range(0, 15) == 0);
      lv = ($urandom_range(0, 1) == 1) ? 8'($urandom) : bcd8($urandom_range(0, 59));
      step(t, s, i, d, l, lv, "rand");
      if ($urandom_range(0, 199) == 0) mid_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
